// File: rtl/traffic_pkg.sv
// Shared light/fault encodings and sequence order for the traffic light sequencer and monitor.
package traffic_pkg;

  localparam logic [2:0] GREEN       = 3'b000;
  localparam logic [2:0] FLASH_GREEN = 3'b001;
  localparam logic [2:0] YELLOW      = 3'b011;
  localparam logic [2:0] RED         = 3'b010;

  localparam logic [1:0] FAULT_NONE          = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL_TRANS = 2'b01;
  localparam logic [1:0] FAULT_DWELL         = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL_CODE  = 2'b11;

  typedef enum logic [1:0] {
    StSync   = 2'b00,
    StLocked = 2'b01,
    StFault  = 2'b10
  } mon_state_e;

  // Legal successor in the green -> flash_green -> yellow -> red -> green loop.
  function automatic logic [2:0] next_light(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      GREEN:       nxt = FLASH_GREEN;
      FLASH_GREEN: nxt = YELLOW;
      YELLOW:      nxt = RED;
      RED:         nxt = GREEN;
      default:     nxt = RED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/phase_dwell_timer.sv
// Saturating per-phase dwell counter with min/max hold comparisons.
module phase_dwell_timer #(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 8,
  localparam int unsigned W = $clog2(MAX_DWELL + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic too_short_o,
  output logic too_long_o
);

  logic [W-1:0] dwell_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
    end else if (clr_i) begin
      dwell_q <= '0;
    end else if (load_i) begin
      dwell_q <= W'(1);
    end else if (inc_i && (dwell_q < W'(MAX_DWELL + 1))) begin
      dwell_q <= dwell_q + W'(1);
    end
  end

  assign too_short_o = dwell_q < W'(MIN_DWELL);
  // One more hold would push the count past the limit.
  assign too_long_o  = dwell_q >= W'(MAX_DWELL);

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks the received light sequence, decodes driver qualifiers and latches a fail-safe fault.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  input  logic             clr_fault,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             go,
  output logic             caution,
  output logic             stop,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] cycles
);

  mon_state_e       state_q, state_d;
  logic [1:0]       phase_d, code_d;
  logic [CNT_W-1:0] cycles_d;
  logic             dw_load, dw_inc, dw_clr, too_short, too_long;
  logic             locked_d;

  phase_dwell_timer #(
    .MIN_DWELL(MIN_DWELL),
    .MAX_DWELL(MAX_DWELL)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dw_load),
    .inc_i      (dw_inc),
    .clr_i      (dw_clr),
    .too_short_o(too_short),
    .too_long_o (too_long)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase;
    code_d   = fault_code;
    cycles_d = cycles;
    dw_load  = 1'b0;
    dw_inc   = 1'b0;
    dw_clr   = 1'b0;
    unique case (state_q)
      StSync: begin
        if (light[2]) begin
          state_d = StFault;
          code_d  = FAULT_ILLEGAL_CODE;
        end else if (light == RED) begin
          state_d = StLocked;
          phase_d = RED[1:0];
          dw_load = 1'b1;
        end
      end
      StLocked: begin
        if (light[2]) begin
          state_d = StFault;
          code_d  = FAULT_ILLEGAL_CODE;
        end else if (light[1:0] == phase) begin
          dw_inc = 1'b1;
          if (too_long) begin
            state_d = StFault;
            code_d  = FAULT_DWELL;
          end
        end else if (light == next_light({1'b0, phase})) begin
          if (too_short) begin
            state_d = StFault;
            code_d  = FAULT_DWELL;
          end else begin
            phase_d = light[1:0];
            dw_load = 1'b1;
            if ((phase == RED[1:0]) && (cycles != '1)) begin
              cycles_d = cycles + CNT_W'(1);
            end
          end
        end else begin
          state_d = StFault;
          code_d  = FAULT_ILLEGAL_TRANS;
        end
      end
      StFault: begin
        // Clear wins over whatever light arrives alongside it.
        if (clr_fault) begin
          state_d = StSync;
          code_d  = FAULT_NONE;
          dw_clr  = 1'b1;
        end
      end
      default: state_d = StSync;
    endcase
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSync;
      phase      <= RED[1:0];
      fault_code <= FAULT_NONE;
      cycles     <= '0;
      locked     <= 1'b0;
      go         <= 1'b0;
      caution    <= 1'b0;
      stop       <= 1'b1;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase      <= phase_d;
      fault_code <= code_d;
      cycles     <= cycles_d;
      locked     <= locked_d;
      go         <= locked_d && ((phase_d == GREEN[1:0]) || (phase_d == FLASH_GREEN[1:0]));
      caution    <= locked_d && (phase_d == YELLOW[1:0]);
      stop       <= !locked_d || (phase_d == RED[1:0]);
      fault      <= (state_d == StFault);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with default parameters.
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b000;
  localparam logic [2:0] F = 3'b001;
  localparam logic [2:0] Y = 3'b011;
  localparam logic [2:0] R = 3'b010;
  localparam logic [2:0] BAD = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light = G;
  logic       clr_fault = 1'b0;
  logic       locked, go, caution, stop, fault;
  logic [1:0] phase, fault_code;
  logic [7:0] cycles;

  int checks = 0;
  int failures = 0;

  traffic_light_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light     (light),
    .clr_fault (clr_fault),
    .locked    (locked),
    .phase     (phase),
    .go        (go),
    .caution   (caution),
    .stop      (stop),
    .fault     (fault),
    .fault_code(fault_code),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [2:0] l, input logic c = 1'b0);
    light = l;
    clr_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({locked, phase, go, caution, stop, fault, fault_code} !== {1'b0, 2'b10, 3'b001, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset_outputs got l=%b ph=%b go=%b ca=%b st=%b f=%b fc=%b", locked, phase, go,
               caution, stop, fault, fault_code);
    end
    checks++;
    if (cycles !== 8'd0) begin failures++; $display("FAIL reset_cycles got %0d want 0", cycles); end
    rst = 1'b0;
    step(G);
    checks++;
    if (locked !== 1'b0 || stop !== 1'b1 || go !== 1'b0) begin
      failures++; $display("FAIL sync_green got locked=%b stop=%b go=%b want 0 1 0", locked, stop, go);
    end
  endtask

  task automatic test_round_trip();
    step(R);
    checks++;
    if (locked !== 1'b1 || stop !== 1'b1 || phase !== 2'b10) begin
      failures++; $display("FAIL rt_lock got locked=%b stop=%b phase=%b want 1 1 10", locked, stop, phase);
    end
    for (int r = 0; r < 3; r++) begin
      step(G);
      checks++;
      if (go !== 1'b1 || caution !== 1'b0 || stop !== 1'b0) begin
        failures++; $display("FAIL rt_green round %0d got go=%b ca=%b st=%b want 1 0 0", r, go, caution, stop);
      end
      step(F);
      checks++;
      if (go !== 1'b1 || phase !== 2'b01) begin
        failures++; $display("FAIL rt_flash round %0d got go=%b phase=%b want 1 01", r, go, phase);
      end
      step(Y);
      checks++;
      if (caution !== 1'b1 || go !== 1'b0 || stop !== 1'b0) begin
        failures++; $display("FAIL rt_yellow round %0d got go=%b ca=%b st=%b want 0 1 0", r, go, caution, stop);
      end
      step(R);
      checks++;
      if (stop !== 1'b1 || go !== 1'b0 || caution !== 1'b0) begin
        failures++; $display("FAIL rt_red round %0d got go=%b ca=%b st=%b want 0 0 1", r, go, caution, stop);
      end
    end
    checks++;
    if (cycles !== 8'd3 || fault !== 1'b0) begin
      failures++; $display("FAIL rt_cycles got cycles=%0d fault=%b want 3 0", cycles, fault);
    end
  endtask

  task automatic test_skip();
    step(Y);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || stop !== 1'b1 || go !== 1'b0 || locked !== 1'b0) begin
      failures++; $display("FAIL skip_fault got f=%b fc=%b st=%b go=%b l=%b want 1 01 1 0 0", fault,
                           fault_code, stop, go, locked);
    end
    step(G);
    step(F);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || go !== 1'b0 || cycles !== 8'd3) begin
      failures++; $display("FAIL skip_sticky got f=%b fc=%b go=%b cycles=%0d want 1 01 0 3", fault,
                           fault_code, go, cycles);
    end
  endtask

  task automatic test_dwell();
    step(G, 1'b1);
    checks++;
    if (fault !== 1'b0 || locked !== 1'b0 || stop !== 1'b1 || fault_code !== 2'b00 || cycles !== 8'd3) begin
      failures++; $display("FAIL clr_basic got f=%b l=%b st=%b fc=%b cycles=%0d want 0 0 1 00 3", fault,
                           locked, stop, fault_code, cycles);
    end
    step(R);
    for (int i = 0; i < 8; i++) step(G);
    checks++;
    if (fault !== 1'b0 || go !== 1'b1 || cycles !== 8'd4) begin
      failures++; $display("FAIL dwell_8_ok got f=%b go=%b cycles=%0d want 0 1 4", fault, go, cycles);
    end
    step(G);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || go !== 1'b0 || stop !== 1'b1) begin
      failures++; $display("FAIL dwell_9_fault got f=%b fc=%b go=%b st=%b want 1 10 0 1", fault,
                           fault_code, go, stop);
    end
    step(BAD);
    checks++;
    if (fault_code !== 2'b10) begin
      failures++; $display("FAIL code_frozen got fc=%b want 10", fault_code);
    end
  endtask

  task automatic test_recovery();
    step(R, 1'b1);
    step(R);
    step(G);
    step(R);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || cycles !== 8'd5) begin
      failures++; $display("FAIL green_to_red got f=%b fc=%b cycles=%0d want 1 01 5", fault, fault_code, cycles);
    end
    step(BAD, 1'b1);
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || locked !== 1'b0 || cycles !== 8'd5 || stop !== 1'b1) begin
      failures++; $display("FAIL clr_wins got f=%b fc=%b l=%b cycles=%0d st=%b want 0 00 0 5 1", fault,
                           fault_code, locked, cycles, stop);
    end
    step(BAD);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b11) begin
      failures++; $display("FAIL illegal_sync got f=%b fc=%b want 1 11", fault, fault_code);
    end
    step(R, 1'b1);
    step(R);
    checks++;
    if (locked !== 1'b1 || fault !== 1'b0 || cycles !== 8'd5) begin
      failures++; $display("FAIL relock got l=%b f=%b cycles=%0d want 1 0 5", locked, fault, cycles);
    end
  endtask

  task automatic test_clr_outside_fault();
    step(R, 1'b1);
    checks++;
    if (locked !== 1'b1 || fault !== 1'b0 || phase !== 2'b10) begin
      failures++; $display("FAIL clr_locked got l=%b f=%b ph=%b want 1 0 10", locked, fault, phase);
    end
    step(G);
    checks++;
    if (go !== 1'b1 || cycles !== 8'd6) begin
      failures++; $display("FAIL clr_then_green got go=%b cycles=%0d want 1 6", go, cycles);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (go !== 1'b0 || stop !== 1'b1 || cycles !== 8'd0 || locked !== 1'b0 || phase !== 2'b10) begin
      failures++; $display("FAIL async_rst got go=%b st=%b cycles=%0d l=%b ph=%b want 0 1 0 0 10", go, stop,
                           cycles, locked, phase);
    end
    #2;
    rst = 1'b0;
    step(G);
    checks++;
    if (locked !== 1'b0 || stop !== 1'b1 || fault !== 1'b0) begin
      failures++; $display("FAIL post_rst_sync got l=%b st=%b f=%b want 0 1 0", locked, stop, fault);
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_skip();
    test_dwell();
    test_recovery();
    test_clr_outside_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
